// File: rtl/rx_frame_fsm_if.sv
// Receive-side bus bundle for rx_frame_fsm: GMII-style input stream plus re-timed stream and verdict.
// Macro RX_FRAME_STATS_EN adds the good/bad frame counter signals.
interface rx_frame_fsm_if #(
  parameter int unsigned pDATA_WIDTH    = 8,
  parameter int unsigned pFSM_BUS_WIDHT = 4,
  parameter int unsigned pLEN_WIDTH     = 12
);
  logic                      idv;
  logic [pDATA_WIDTH-1:0]    irx_d;
  logic                      irx_er;
  logic                      odv;
  logic [pDATA_WIDTH-1:0]    orx_d;
  logic                      orx_er;
  logic [pFSM_BUS_WIDHT-1:0] oframe_state;
  logic                      ofrm_done;
  logic                      ofrm_ok;
  logic                      ocrc_err;
  logic                      olen_err;
  logic                      orx_err;
  logic [pLEN_WIDTH-1:0]     olen;
`ifdef RX_FRAME_STATS_EN
  logic                      iclr_stats;
  logic [15:0]               ogood_cnt;
  logic [15:0]               obad_cnt;

  modport master (
    output idv, irx_d, irx_er, iclr_stats,
    input  odv, orx_d, orx_er, oframe_state, ofrm_done, ofrm_ok, ocrc_err, olen_err, orx_err,
    input  olen, ogood_cnt, obad_cnt
  );
  modport slave (
    input  idv, irx_d, irx_er, iclr_stats,
    output odv, orx_d, orx_er, oframe_state, ofrm_done, ofrm_ok, ocrc_err, olen_err, orx_err,
    output olen, ogood_cnt, obad_cnt
  );
`else
  modport master (
    output idv, irx_d, irx_er,
    input  odv, orx_d, orx_er, oframe_state, ofrm_done, ofrm_ok, ocrc_err, olen_err, orx_err,
    input  olen
  );
  modport slave (
    input  idv, irx_d, irx_er,
    output odv, orx_d, orx_er, oframe_state, ofrm_done, ofrm_ok, ocrc_err, olen_err, orx_err,
    output olen
  );
`endif
endinterface

// File: rtl/rx_frame_fsm.sv
// Receive frame tracker: labels each byte with its frame field, runs CRC-32 and length checks,
// and emits an end-of-frame verdict. Macro RX_FRAME_STATS_EN adds saturating good/bad counters.
module rx_frame_fsm #(
  parameter int unsigned pDATA_WIDTH        = 8,
  parameter int unsigned pMIN_PACKET_LENGHT = 64,
  parameter int unsigned pMAX_PACKET_LENGHT = 1536,
  parameter int unsigned pFSM_BUS_WIDHT     = 4,
  parameter int unsigned pLEN_WIDTH         = $clog2(pMAX_PACKET_LENGHT) + 1
) (
  input logic           iclk,
  input logic           irst,
  rx_frame_fsm_if.slave bus
);

  typedef enum logic [3:0] {
    lpIDLE     = 4'd0,
    lpPREAMBLE = 4'd1,
    lpSFD      = 4'd2,
    lpDA       = 4'd3,
    lpSA       = 4'd4,
    lpTYPE     = 4'd5,
    lpDATA     = 4'd6,
    lpCHECK    = 4'd7,
    lpDROP     = 4'd8
  } state_e;

  localparam logic [pDATA_WIDTH-1:0] PreByte = pDATA_WIDTH'(8'h55);
  localparam logic [pDATA_WIDTH-1:0] SfdByte = pDATA_WIDTH'(8'hD5);
  localparam logic [31:0]            CrcPoly = 32'hEDB8_8320;
  localparam logic [31:0]            CrcGood = 32'hDEBB_20E3;
  localparam logic [pLEN_WIDTH-1:0]  DaEnd   = pLEN_WIDTH'(6);
  localparam logic [pLEN_WIDTH-1:0]  SaEnd   = pLEN_WIDTH'(12);
  localparam logic [pLEN_WIDTH-1:0]  TypeEnd = pLEN_WIDTH'(14);
  localparam logic [pLEN_WIDTH-1:0]  MinLen  = pLEN_WIDTH'(pMIN_PACKET_LENGHT);
  localparam logic [pLEN_WIDTH-1:0]  MaxLen  = pLEN_WIDTH'(pMAX_PACKET_LENGHT);

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
    end
    return c;
  endfunction

  state_e                 state_q, state_d;
  logic [pLEN_WIDTH-1:0]  len_q, len_d;
  logic [31:0]            crc_q, crc_d;
  logic                   err_q, err_d;
  logic                   dv_q;
  logic [pDATA_WIDTH-1:0] d_q;
  logic                   er_q;
  logic                   in_frame;

  logic                   frm_done, frm_ok, crc_err, len_err, rx_err;
  logic [pLEN_WIDTH-1:0]  frm_len;

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state_q <= lpIDLE;
      len_q   <= '0;
      crc_q   <= '1;
      err_q   <= 1'b0;
      dv_q    <= 1'b0;
      d_q     <= '0;
      er_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      crc_q   <= crc_d;
      err_q   <= err_d;
      dv_q    <= bus.idv;
      d_q     <= bus.irx_d;
      er_q    <= bus.irx_er;
    end
  end

  // state_d labels the byte currently on irx_d; it becomes the label of orx_d next cycle.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    crc_d   = crc_q;
    err_d   = err_q;
    unique case (state_q)
      lpIDLE, lpCHECK: begin
        if (!bus.idv)                  state_d = lpIDLE;
        else if (bus.irx_d == PreByte) state_d = lpPREAMBLE;
        else if (bus.irx_d == SfdByte) state_d = lpSFD;
        else                           state_d = lpDROP;
      end
      lpPREAMBLE: begin
        if (!bus.idv)                  state_d = lpIDLE;
        else if (bus.irx_d == PreByte) state_d = lpPREAMBLE;
        else if (bus.irx_d == SfdByte) state_d = lpSFD;
        else                           state_d = lpDROP;
      end
      lpSFD:   state_d = bus.idv ? lpDA : lpCHECK;
      lpDA:    state_d = !bus.idv ? lpCHECK : ((len_q < DaEnd) ? lpDA : lpSA);
      lpSA:    state_d = !bus.idv ? lpCHECK : ((len_q < SaEnd) ? lpSA : lpTYPE);
      lpTYPE:  state_d = !bus.idv ? lpCHECK : ((len_q < TypeEnd) ? lpTYPE : lpDATA);
      lpDATA:  state_d = bus.idv ? lpDATA : lpCHECK;
      lpDROP:  state_d = bus.idv ? lpDROP : lpIDLE;
      default: state_d = lpIDLE;
    endcase

    in_frame = (state_d == lpDA) || (state_d == lpSA) || (state_d == lpTYPE) ||
               (state_d == lpDATA);
    if (state_d == lpSFD) begin
      len_d = '0;
      crc_d = '1;
      err_d = bus.irx_er;
    end else if (in_frame) begin
      len_d = (len_q == '1) ? len_q : len_q + pLEN_WIDTH'(1);
      crc_d = crc_byte(crc_q, bus.irx_d[7:0]);
      err_d = err_q | bus.irx_er;
    end
  end

  always_comb begin
    frm_done = (state_q == lpCHECK);
    crc_err  = frm_done & (crc_q != CrcGood);
    len_err  = frm_done & ((len_q < MinLen) | (len_q > MaxLen));
    rx_err   = frm_done & err_q;
    frm_ok   = frm_done & ~crc_err & ~len_err & ~rx_err;
    frm_len  = frm_done ? len_q : '0;
  end

  assign bus.odv          = dv_q;
  assign bus.orx_d        = d_q;
  assign bus.orx_er       = er_q;
  assign bus.oframe_state = pFSM_BUS_WIDHT'(state_q);
  assign bus.ofrm_done    = frm_done;
  assign bus.ofrm_ok      = frm_ok;
  assign bus.ocrc_err     = crc_err;
  assign bus.olen_err     = len_err;
  assign bus.orx_err      = rx_err;
  assign bus.olen         = frm_len;

`ifdef RX_FRAME_STATS_EN
  logic [15:0] good_q, good_d;
  logic [15:0] bad_q, bad_d;

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      good_q <= good_d;
      bad_q  <= bad_d;
    end
  end

  // Clear wins over a same-cycle verdict.
  always_comb begin
    good_d = good_q;
    bad_d  = bad_q;
    if (bus.iclr_stats) begin
      good_d = '0;
      bad_d  = '0;
    end else if (frm_done) begin
      if (frm_ok && good_q != 16'hFFFF)       good_d = good_q + 16'd1;
      else if (!frm_ok && bad_q != 16'hFFFF)  bad_d  = bad_q + 16'd1;
    end
  end

  assign bus.ogood_cnt = good_q;
  assign bus.obad_cnt  = bad_q;
`endif

endmodule

// File: tb/tb_rx_frame_fsm.sv
// Scoreboard bench for rx_frame_fsm: a driver queues per-cycle and per-frame expectations from a
// frame-level model, a monitor compares every cycle and every verdict.
module tb_rx_frame_fsm;

  localparam logic [3:0] StIdle  = 4'd0;
  localparam logic [3:0] StPre   = 4'd1;
  localparam logic [3:0] StSfd   = 4'd2;
  localparam logic [3:0] StDa    = 4'd3;
  localparam logic [3:0] StSa    = 4'd4;
  localparam logic [3:0] StType  = 4'd5;
  localparam logic [3:0] StData  = 4'd6;
  localparam logic [3:0] StCheck = 4'd7;
  localparam logic [3:0] StDrop  = 4'd8;

  typedef struct {
    logic [3:0] st;
    logic       dv;
    logic [7:0] d;
    logic       er;
  } cyc_t;

  typedef struct {
    int   len;
    logic crc_err;
    logic len_err;
    logic rx_err;
  } vrd_t;

  logic iclk = 1'b0;
  logic irst = 1'b0;

  rx_frame_fsm_if bus ();

  rx_frame_fsm dut (
    .iclk (iclk),
    .irst (irst),
    .bus  (bus)
  );

  always #5 iclk = ~iclk;

  cyc_t       cyc_q[$];
  vrd_t       vrd_q[$];
  logic [7:0] fbuf[$];
  int         checks = 0;
  int         passes = 0;
  int         good_n = 0;
  int         bad_n  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_crc(input int cnt);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < cnt; k++) begin
      c = c ^ {24'h0, fbuf[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // A frame is good when its last four bytes carry the CRC of the rest, LSB byte first.
  function automatic logic fcs_ok(input int n);
    if (n < 4) return 1'b0;
    return {fbuf[n-1], fbuf[n-2], fbuf[n-3], fbuf[n-4]} == ref_crc(n - 4);
  endfunction

  task automatic make_frame(input int n);
    logic [31:0] c;
    fbuf.delete();
    for (int i = 0; i < n - 4; i++) fbuf.push_back(8'($urandom));
    c = ref_crc(n - 4);
    fbuf.push_back(c[7:0]);
    fbuf.push_back(c[15:8]);
    fbuf.push_back(c[23:16]);
    fbuf.push_back(c[31:24]);
  endtask

  task automatic drive(input logic dv, input logic [7:0] d, input logic er, input logic [3:0] st,
                       input logic rst_v);
    cyc_t e;
    @(negedge iclk);
    irst       = rst_v;
    bus.idv    = dv;
    bus.irx_d  = d;
    bus.irx_er = er;
    if (rst_v) begin
      e.st = st; e.dv = dv; e.d = d; e.er = er;
    end else begin
      e.st = StIdle; e.dv = 1'b0; e.d = 8'h00; e.er = 1'b0;
      good_n = 0;
      bad_n  = 0;
    end
    cyc_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 1'b0, StIdle, 1'b1);
  endtask

  // Sends the frame in fbuf; er_idx < 0 means no PHY error.
  task automatic send_frame(input int npre, input int er_idx);
    vrd_t       v;
    int         n;
    logic [3:0] st;
    n = fbuf.size();
    for (int i = 0; i < npre; i++) drive(1'b1, 8'h55, 1'b0, StPre, 1'b1);
    drive(1'b1, 8'hD5, 1'b0, StSfd, 1'b1);
    for (int i = 0; i < n; i++) begin
      st = (i < 6) ? StDa : (i < 12) ? StSa : (i < 14) ? StType : StData;
      drive(1'b1, fbuf[i], (i == er_idx), st, 1'b1);
    end
    v.len     = (n > 4095) ? 4095 : n;
    v.crc_err = !fcs_ok(n);
    v.len_err = (n < 64) || (n > 1536);
    v.rx_err  = (er_idx >= 0) && (er_idx < n);
    vrd_q.push_back(v);
    drive(1'b0, 8'($urandom), 1'b0, StCheck, 1'b1);
  endtask

  // Monitor: one expected cycle per clock, one expected verdict per ofrm_done.
  initial begin
    cyc_t e;
    vrd_t v;
    logic ok;
    forever begin
      @(posedge iclk);
      #1;
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("stream{state,dv,d,er}", {bus.oframe_state, bus.odv, bus.orx_d, bus.orx_er},
            {e.st, e.dv, e.d, e.er});
        chk("ofrm_done", bus.ofrm_done, (e.st == StCheck));
      end
      if (bus.ofrm_done) begin
        if (vrd_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          v  = vrd_q.pop_front();
          ok = !(v.crc_err || v.len_err || v.rx_err);
          chk("olen", bus.olen, v.len);
          chk("ocrc_err", bus.ocrc_err, v.crc_err);
          chk("olen_err", bus.olen_err, v.len_err);
          chk("orx_err", bus.orx_err, v.rx_err);
          chk("ofrm_ok", bus.ofrm_ok, ok);
          if (ok) good_n++;
          else    bad_n++;
        end
      end else begin
        chk("verdict_idle", {bus.ofrm_ok, bus.ocrc_err, bus.olen_err, bus.orx_err, bus.olen}, 0);
      end
    end
  end

  initial begin
    int n, npre, er_idx, sel;
    bus.idv    = 1'b0;
    bus.irx_d  = 8'h00;
    bus.irx_er = 1'b0;
`ifdef RX_FRAME_STATS_EN
    bus.iclr_stats = 1'b0;
`endif
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0, StIdle, 1'b0);
    idle(2);

    // Good 64-byte frame, then one corrupted at byte 20.
    make_frame(64);
    send_frame(7, -1);
    idle(2);
    make_frame(64);
    fbuf[20] = fbuf[20] ^ 8'h01;
    send_frame(7, -1);
    idle(1);

    // Length boundaries.
    make_frame(60);   send_frame(7, -1); idle(1);
    make_frame(63);   send_frame(3, -1); idle(1);
    make_frame(1536); send_frame(7, -1); idle(1);
    make_frame(1537); send_frame(7, -1); idle(1);

    // PHY error on byte 30 of a good 100-byte frame.
    make_frame(100);
    send_frame(7, 30);
    idle(1);

    // Bad preamble byte: drop until idv falls, then a clean frame.
    drive(1'b1, 8'h55, 1'b0, StPre, 1'b1);
    drive(1'b1, 8'h55, 1'b0, StPre, 1'b1);
    drive(1'b1, 8'h00, 1'b0, StDrop, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 8'($urandom), 1'b0, StDrop, 1'b1);
    drive(1'b0, 8'h00, 1'b0, StIdle, 1'b1);
    make_frame(72);
    send_frame(7, -1);

    // Back-to-back with short preamble, frame cut in DA, and aborted preamble.
    make_frame(80);
    send_frame(0, -1);
    fbuf.delete();
    for (int i = 0; i < 3; i++) fbuf.push_back(8'($urandom));
    send_frame(2, -1);
    drive(1'b1, 8'h55, 1'b0, StPre, 1'b1);
    drive(1'b1, 8'h55, 1'b0, StPre, 1'b1);
    idle(2);

    // Asynchronous reset mid-DA, released while data bytes are still arriving.
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0, StPre, 1'b1);
    drive(1'b1, 8'hD5, 1'b0, StSfd, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'hA0 + 8'(i), 1'b0, StDa, 1'b1);
    @(posedge iclk);
    #2;
    irst = 1'b0;
    good_n = 0;
    bad_n  = 0;
    #1;
    chk("reset_outputs", {bus.odv, bus.orx_d, bus.orx_er, bus.ofrm_done, bus.olen}, 0);
    chk("reset_state", bus.oframe_state, StIdle);
    drive(1'b1, 8'h12, 1'b0, StIdle, 1'b0);
    drive(1'b1, 8'h34, 1'b0, StIdle, 1'b0);
    drive(1'b1, 8'h56, 1'b0, StDrop, 1'b1);
    drive(1'b1, 8'h78, 1'b0, StDrop, 1'b1);
    drive(1'b1, 8'h9A, 1'b0, StDrop, 1'b1);
    idle(2);

    // Randomised frames.
    for (int f = 0; f < 40; f++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       n = $urandom_range(64, 160);
      else if (sel == 7) n = $urandom_range(4, 63);
      else if (sel == 8) n = $urandom_range(1500, 1540);
      else               n = $urandom_range(14, 80);
      npre = $urandom_range(0, 7);
      make_frame(n);
      if ($urandom_range(0, 4) == 0) begin
        sel = $urandom_range(0, n - 1);
        fbuf[sel] = fbuf[sel] ^ 8'($urandom_range(1, 255));
      end
      er_idx = ($urandom_range(0, 6) == 0) ? $urandom_range(0, n - 1) : -1;
      send_frame(npre, er_idx);
      idle($urandom_range(0, 3));
    end

    idle(4);
    @(posedge iclk);
    #2;
    chk("pending_cycles", cyc_q.size(), 0);
    chk("pending_verdicts", vrd_q.size(), 0);
`ifdef RX_FRAME_STATS_EN
    chk("ogood_cnt", bus.ogood_cnt, good_n);
    chk("obad_cnt", bus.obad_cnt, bad_n);
    @(negedge iclk);
    bus.iclr_stats = 1'b1;
    @(negedge iclk);
    bus.iclr_stats = 1'b0;
    chk("stats_clear", {bus.ogood_cnt, bus.obad_cnt}, 0);
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
